// File: rtl/spi_tx_master.sv
// SPI mode-0 master, MSB first: streams bytes out on MOSI under one active-low select
// per frame and returns the byte sampled from MISO for every byte sent.
module spi_tx_master #(
   parameter int CLK_DIV  = 50,
   parameter int NUM_SS   = 2,
   parameter int SEL_W    = 1,
   parameter int CS_SETUP = 10,
   parameter int CS_HOLD  = 10,
   parameter int GAP      = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        tx_data,
   input  logic              tx_valid,
   input  logic              tx_last,
   input  logic [SEL_W-1:0]  tx_sel,
   output logic              tx_ready,
   output logic [7:0]        rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ssel
);

   localparam int M1    = (CLK_DIV > GAP) ? CLK_DIV : GAP;
   localparam int M2    = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int MAXC  = (M1 > M2) ? M1 : M2;
   localparam int CNT_W = $clog2(MAXC) + 1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LO, S_HI, S_WAIT, S_HOLD, S_GAP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       tx_sh;
   logic [7:0]       rx_sh;
   logic             last_q;
   logic             sel_ok;

   assign sel_ok   = (32'(tx_sel) < 32'(NUM_SS));
   assign tx_ready = !rst && (state == S_IDLE || state == S_WAIT);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         last_q   <= 1'b0;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         ssel     <= {NUM_SS{1'b1}};
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               // An out-of-range select consumes the byte without starting a frame.
               if (tx_valid && sel_ok) begin
                  tx_sh   <= tx_data;
                  mosi    <= tx_data[7];
                  last_q  <= tx_last;
                  bit_cnt <= 3'd7;
                  ssel    <= ~(NUM_SS'(1) << tx_sel);
                  cnt     <= CNT_W'(CS_SETUP - 1);
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt == '0) begin
                  cnt   <= CNT_W'(CLK_DIV - 1);
                  state <= S_LO;
               end else cnt <= cnt - 1'b1;
            end
            S_LO: begin
               if (cnt == '0) begin
                  sck   <= 1'b1;
                  cnt   <= CNT_W'(CLK_DIV - 1);
                  state <= S_HI;
               end else cnt <= cnt - 1'b1;
            end
            S_HI: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) rx_sh <= {rx_sh[6:0], miso};
               if (cnt == '0) begin
                  sck <= 1'b0;
                  cnt <= CNT_W'(CLK_DIV - 1);
                  if (bit_cnt != 3'd0) begin
                     bit_cnt <= bit_cnt - 3'd1;
                     tx_sh   <= {tx_sh[6:0], 1'b0};
                     mosi    <= tx_sh[6];
                     state   <= S_LO;
                  end else begin
                     rx_valid <= 1'b1;
                     rx_data  <= rx_sh;
                     if (last_q) begin
                        cnt   <= CNT_W'(CS_HOLD - 1);
                        state <= S_HOLD;
                     end else state <= S_WAIT;
                  end
               end else cnt <= cnt - 1'b1;
            end
            S_WAIT: begin
               // The first LO half-period of the next byte doubles as data setup.
               if (tx_valid) begin
                  tx_sh   <= tx_data;
                  mosi    <= tx_data[7];
                  last_q  <= tx_last;
                  bit_cnt <= 3'd7;
                  cnt     <= CNT_W'(CLK_DIV - 1);
                  state   <= S_LO;
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  ssel  <= {NUM_SS{1'b1}};
                  cnt   <= CNT_W'(GAP - 1);
                  state <= S_GAP;
               end else cnt <= cnt - 1'b1;
            end
            S_GAP: begin
               if (cnt == '0) state <= S_IDLE;
               else cnt <= cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_master.sv
// Bench for spi_tx_master: frame-level model built from the byte stream, checked
// against what a passive SPI monitor observes on the wires.
`timescale 1ns/1ps
module tb_spi_tx_master;

   localparam int CLK_DIV  = 4;
   localparam int NUM_SS   = 2;
   localparam int SEL_W    = 2;
   localparam int CS_SETUP = 3;
   localparam int CS_HOLD  = 5;
   localparam int GAP      = 20;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       tx_data = '0;
   logic             tx_valid = 1'b0;
   logic             tx_last = 1'b0;
   logic [SEL_W-1:0] tx_sel = '0;
   logic             tx_ready;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             busy;
   logic             sck;
   logic             mosi;
   logic             miso;
   logic [NUM_SS-1:0] ssel;
   logic             inv = 1'b0;

   assign miso = mosi ^ inv;

   spi_tx_master #(.CLK_DIV(CLK_DIV), .NUM_SS(NUM_SS), .SEL_W(SEL_W), .CS_SETUP(CS_SETUP),
                   .CS_HOLD(CS_HOLD), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_sel(tx_sel), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .sck(sck), .mosi(mosi), .miso(miso), .ssel(ssel));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Passive wire monitor
   logic        sck_p = 1'b0;
   logic [1:0]  ssel_p = 2'b11;
   int          cyc = 0, fall_cyc = 0, gap_start = 0, hold_meas = -1;
   int          min_gap = 1 << 30, bad = 0;
   bit          have_rise = 1'b0;
   logic        mosi_q[$];
   logic [1:0]  sselr_q[$];
   logic [7:0]  rx_q[$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (sck && !sck_p) begin
            mosi_q.push_back(mosi);
            sselr_q.push_back(ssel);
         end
         if (!sck && sck_p) fall_cyc <= cyc;
         if (ssel == 2'b11 && ssel_p != 2'b11) begin
            hold_meas <= cyc - fall_cyc;
            gap_start <= cyc;
            have_rise <= 1'b1;
         end
         if (ssel != 2'b11 && ssel_p == 2'b11 && have_rise && (cyc - gap_start) < min_gap)
            min_gap <= cyc - gap_start;
         if (rx_valid) rx_q.push_back(rx_data);
         if ($countones(~ssel) > 1 || (sck && ssel == 2'b11) || (tx_ready && busy && ssel == 2'b11))
            bad <= bad + 1;
      end
      sck_p  <= sck;
      ssel_p <= ssel;
   end

   logic [7:0] fb[4];
   int         fn;
   logic [1:0] fs;

   task automatic send(input logic [7:0] d, input bit l, input logic [1:0] s);
      int n = 0;
      tx_data = d; tx_last = l; tx_sel = s; tx_valid = 1'b1;
      while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000) check("tx_ready_timeout", tx_ready, 1'b1);
      @(posedge clk); #1 tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20000) begin @(negedge clk); n++; end
      if (busy) check("idle_timeout", busy, 1'b0);
   endtask

   task automatic run_frame(input bit do_stall);
      int m0 = mosi_q.size();
      int r0 = rx_q.size();
      logic [31:0] exp_bits = '0, got_bits = '0;
      logic [1:0]  exp_ssel;
      int bad_sel = 0, bad_stall = 0, n = 0;
      exp_ssel = ~(2'b01 << fs);
      for (int i = 0; i < fn; i++) begin
         send(fb[i], (i == fn - 1), fs);
         if (do_stall && i == 0 && fn > 1) begin
            n = 0;
            while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
            repeat (200) begin
               @(negedge clk);
               if (sck !== 1'b0 || ssel !== exp_ssel || tx_ready !== 1'b1) bad_stall++;
            end
            check("stall_hold", bad_stall, 0);
         end
      end
      wait_idle();
      for (int i = 0; i < fn; i++) exp_bits = {exp_bits[23:0], fb[i]};
      for (int j = 0; j < mosi_q.size() - m0 && j < 32; j++) begin
         got_bits = {got_bits[30:0], mosi_q[m0 + j]};
         if (sselr_q[m0 + j] !== exp_ssel) bad_sel++;
      end
      check("rise_count", mosi_q.size() - m0, 8 * fn);
      check("mosi_bits", got_bits, exp_bits);
      check("ssel_at_rise", bad_sel, 0);
      check("rx_count", rx_q.size() - r0, fn);
      for (int i = 0; i < fn && r0 + i < rx_q.size(); i++)
         check("rx_byte", rx_q[r0 + i], fb[i] ^ {8{inv}});
      check("cs_hold", hold_meas, CS_HOLD);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int m0, r0, n, quiet;
      repeat (3) @(negedge clk);
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_ssel", ssel, 2'b11);
      check("rst_tx_ready", tx_ready, 1'b0);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("idle_tx_ready", tx_ready, 1'b1);

      // Directed frames
      fb[0] = 8'hAA; fb[1] = 8'h55; fb[2] = 8'h00; fn = 3; fs = 2'd0; inv = 1'b0;
      run_frame(1'b0);
      fb[0] = 8'h00; fb[1] = 8'h55; fb[2] = 8'hAA; fn = 3; fs = 2'd1;
      run_frame(1'b0);
      fb[0] = 8'hC3; fb[1] = 8'h3C; fn = 2; fs = 2'd0; inv = 1'b1;
      run_frame(1'b1);

      // Randomized back-to-back frames
      repeat (5) begin
         fn  = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
         fs  = 2'($urandom_range(0, 1));
         inv = 1'($urandom_range(0, 1));
         run_frame(1'b0);
      end
      check("min_gap_ok", (min_gap >= GAP), 1'b1);

      // Reset in the middle of bit 4
      inv = 1'b0;
      m0 = mosi_q.size(); r0 = rx_q.size();
      send(8'hF0, 1'b0, 2'd0);
      n = 0;
      while (mosi_q.size() < m0 + 4 && n < 5000) begin @(negedge clk); n++; end
      check("reached_bit4", mosi_q.size() - m0, 4);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("arst_sck", sck, 1'b0);
      check("arst_ssel", ssel, 2'b11);
      check("arst_mosi", mosi, 1'b0);
      check("arst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("abort_no_rx", rx_q.size() - r0, 0);
      fb[0] = 8'h96; fb[1] = 8'h0F; fn = 2; fs = 2'd1;
      run_frame(1'b0);

      // Out-of-range select is swallowed
      m0 = mosi_q.size(); quiet = 0;
      send(8'hA5, 1'b1, 2'd3);
      repeat (40) begin
         @(negedge clk);
         if (busy !== 1'b0 || ssel !== 2'b11) quiet++;
      end
      check("sel_oob_quiet", quiet, 0);
      check("sel_oob_no_sck", mosi_q.size() - m0, 0);
      check("sel_oob_ready", tx_ready, 1'b1);

      check("invariants", bad, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_tx_master.md
Name: spi_tx_master

Overview:
- SPI mode-0 master and transmitter, MSB first. It is the initiating end of the link that the neopixel SPI receiver slave accepts.
- Takes bytes over a valid/ready stream and drives SCK, MOSI and one active-low slave select per output channel.
- Samples MISO and returns one received byte per transmitted byte.
- Used as the on-chip stimulus/bridge source that feeds pixel frames to the SPI receiver from internal logic.

Parameters:
- CLK_DIV, 50: clk cycles per SCK half-period (50 MHz clk gives 500 kHz SCK). Must be >= 2.
- NUM_SS, 2: number of slave-select outputs.
- SEL_W, 1: width of tx_sel. Must satisfy 2**SEL_W >= NUM_SS.
- CS_SETUP, 10: clk cycles from ssel falling to the first SCK rising-edge half-period start.
- CS_HOLD, 10: clk cycles from the last SCK falling edge to ssel rising.
- GAP, 100: minimum clk cycles with all ssel high between frames.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: tx_data is valid.
- tx_last, in, 1: this byte ends the frame; ssel deasserts after it.
- tx_sel, in, SEL_W: slave index. Sampled only on the first byte of a frame.
- tx_ready, out, 1: byte accepted this cycle when tx_valid is also high.
- rx_data, out, 8: byte shifted in from MISO.
- rx_valid, out, 1: one-cycle pulse; rx_data is valid.
- busy, out, 1: high in every state except IDLE.
- sck, out, 1: SPI clock, idles low.
- mosi, out, 1: SPI data out.
- miso, in, 1: SPI data in. Externally synchronised.
- ssel, out, NUM_SS: active-low selects; at most one bit is low at any time.

Behaviour:
- Reset (asynchronous, immediate, also mid-byte): state=IDLE, sck=0, mosi=0, ssel=all 1s, tx_ready=0, rx_valid=0, rx_data=0, busy=0. Any partial frame is abandoned.
- Handshake: a byte transfers on a cycle where tx_valid & tx_ready. tx_ready is combinational from state: high in IDLE, and in WAIT_NEXT. It is low in every other state.
- States:
  - IDLE: on accept, latch data/last/sel; ssel[sel]=0; go to SETUP. If sel >= NUM_SS, the byte is accepted and dropped: no ssel asserts, stay in IDLE.
  - SETUP: count CS_SETUP cycles; mosi=data[7]; then go to LO.
  - LO: sck=0 for CLK_DIV cycles, then go to HI.
  - HI: sck=1 for CLK_DIV cycles. miso is sampled into the rx shift register on the first HI cycle (the SCK rising edge). At the end of HI:
    - If bits remain, shift, mosi=next bit, go to LO. mosi changes only on the cycle sck falls.
    - After bit 0, pulse rx_valid with the full byte and drive sck=0. If last, go to HOLD; otherwise go to WAIT_NEXT.
  - WAIT_NEXT: sck=0, ssel held low, tx_ready=1. On accept, mosi=data[7] and go to LO. The first LO half-period of the byte counts as setup. Stalls indefinitely without tx_valid.
  - HOLD: CS_HOLD cycles, then ssel all high, go to GAP.
  - GAP: GAP cycles, then go to IDLE. tx_ready=0 throughout.
- Byte time inside a burst: 16*CLK_DIV cycles, plus 1 cycle in WAIT_NEXT when tx_valid is already high.
- tx_sel and tx_last are ignored on non-first bytes except that last is latched per byte.
- A one-byte frame (tx_last on the first byte) runs IDLE→SETUP→LO/HI×8→HOLD→GAP.
- Counters saturate-free. The bit counter is 3 bits and counts 7→0. The half-period counter reloads with CLK_DIV-1.

Test Plan:
- CLK_DIV=4, frame sel=0, bytes AA,55,00 (last on 00):
  - ssel[0] low for the whole frame; ssel[1] stays high.
  - 24 sck rising edges.
  - mosi sampled at rising edges = 101010100101010100000000.
  - ssel rises CS_HOLD cycles after the 24th falling edge.
- MISO loopback (miso=mosi), frame 00,55,AA on sel=1: rx_valid pulses 3 times with rx_data 00,55,AA; ssel[1] is the only select low.
- Stall: deassert tx_valid for 200 cycles after byte 1 → sck stays 0, ssel stays low, tx_ready high throughout; byte 2 then resumes correctly.
- Back-to-back frames with tx_valid held high → all ssel high for ≥ GAP cycles between frames; tx_ready low during HOLD/GAP.
- Assert rst during bit 4 of a byte → sck=0, ssel=2'b11, mosi=0 in the same cycle; no rx_valid; after release a new frame transfers cleanly.
- tx_sel=3 with NUM_SS=2 (SEL_W=2) → byte consumed, no ssel activity, no sck edges, busy stays 0.
